tdm_mux4: RTL and testbench

Four-channel time-division multiplexer: the transmitting end of the 1-to-4 select/data demultiplexer interface (`s1`, `s2`, `d`). It samples four channel bits as one coherent frame and serializes them, one channel per clock, onto a 2-bit select plus a data bit. Slots are skippable per channel via a mask. It sits upstream of the existing demultiplexer, which routes each `d` to `y{s1,s2}`.

---
 rtl/tdm_mux4.sv | 190 +++++++++++++++++++
 tb/tb_tdm_mux4.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/tdm_mux4.sv
// -----------------------------------------------------------------------------
// tdm_mux4
//
// Four-channel time-division multiplexer. Samples four channel bits as one
// coherent frame and serializes them, one enabled channel per clock, onto a
// 2-bit slot select ({s1,s2}) plus a data bit (d). This is the transmitting
// end of the 1-to-4 select/data demultiplexer link: downstream, each d is
// routed to y{s1,s2}.
//
// Ports
//   clk          in   system clock, all state changes on the rising edge
//   rst          in   synchronous active-high reset, highest priority
//   en           in   frame request, only looked at on frame boundaries
//   din[3:0]     in   channel data, din[i] belongs to channel i
//   chan_mask    in   channel enable, bit i = 1 gives channel i a slot
//   s1           out  slot index MSB (registered)
//   s2           out  slot index LSB (registered)
//   d            out  data bit of the current slot (registered)
//   valid        out  s1/s2/d carry a live slot this cycle
//   frame_start  out  first slot of a frame
//   frame_end    out  last slot of a frame (may coincide with frame_start)
//
// Behaviour summary
//   A frame is captured when en=1 and chan_mask!=0, either while idle or on
//   the edge that retires the last slot of the running frame, so back-to-back
//   frames have no gap cycle. Once captured, din and chan_mask are frozen in
//   frame_buf/mask_buf; later changes on the inputs only affect the next
//   frame. Slots are emitted in ascending channel order and disabled channels
//   take no cycle, so a frame with k enabled channels is exactly k cycles.
//   All outputs come straight from flops; nothing on the inputs reaches the
//   outputs combinationally.
// -----------------------------------------------------------------------------
module tdm_mux4 (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [3:0] din,
    input  logic [3:0] chan_mask,
    output logic       s1,
    output logic       s2,
    output logic       d,
    output logic       valid,
    output logic       frame_start,
    output logic       frame_end
);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t     state;
    logic [3:0] frame_buf;   // data captured at frame start
    logic [3:0] mask_buf;    // channel mask captured at frame start
    logic [1:0] idx;         // channel index of the slot currently on the outputs

    // -------------------------------------------------------------------------
    // Mask search helpers
    // -------------------------------------------------------------------------

    // Lowest set bit of m at or above position start. Only called when such a
    // bit is known to exist; returns 0 otherwise.
    function automatic logic [1:0] lowest_from(input logic [3:0] m, input int start);
        logic [1:0] r;
        r = 2'd0;
        // Scan downwards so the last hit written is the lowest one.
        for (int k = 3; k >= 0; k--) begin
            if (k >= start && m[k]) begin
                r = k[1:0];
            end
        end
        return r;
    endfunction

    // True when m has any set bit at or above position start.
    function automatic logic any_from(input logic [3:0] m, input int start);
        logic r;
        r = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k >= start && m[k]) begin
                r = 1'b1;
            end
        end
        return r;
    endfunction

    // -------------------------------------------------------------------------
    // Next-slot decode
    // -------------------------------------------------------------------------
    logic       capture;     // a new frame is taken at this edge
    logic [1:0] cap_idx;     // first enabled channel of the incoming frame
    logic       cap_last;    // incoming frame has only that one channel
    logic [1:0] nxt_idx;     // next enabled channel of the running frame
    logic       nxt_last;    // that channel is the last of the running frame

    always_comb begin
        // NOTE: every output of a combinational block is given a value before
        // any branch, so no path can leave it unassigned and infer a latch.
        capture  = 1'b0;
        cap_idx  = 2'd0;
        cap_last = 1'b0;
        nxt_idx  = 2'd0;
        nxt_last = 1'b0;

        // Frame boundary: idle, or the slot on the outputs is the last one.
        if (en && (chan_mask != 4'd0) && (state == IDLE || frame_end)) begin
            capture = 1'b1;
        end

        cap_idx  = lowest_from(chan_mask, 0);
        cap_last = !any_from(chan_mask, int'(cap_idx) + 1);

        // Only meaningful in RUN when the current slot is not the last, which
        // guarantees a higher enabled channel exists in mask_buf.
        nxt_idx  = lowest_from(mask_buf, int'(idx) + 1);
        nxt_last = !any_from(mask_buf, int'(nxt_idx) + 1);
    end

    // -------------------------------------------------------------------------
    // State machine and output registers
    // -------------------------------------------------------------------------
    // NOTE: all state here is sequential and uses non-blocking assignments so
    // every register samples the pre-edge values of the others; blocking
    // assignments would make the result depend on statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: frame_buf/mask_buf are a handful of flops, not a memory
            // array, so clearing them on reset is cheap and makes the
            // post-reset state fully defined.
            state       <= IDLE;
            frame_buf   <= 4'd0;
            mask_buf    <= 4'd0;
            idx         <= 2'd0;
            s1          <= 1'b0;
            s2          <= 1'b0;
            d           <= 1'b0;
            valid       <= 1'b0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
        end else if (capture) begin
            // Start of frame: freeze inputs and emit the lowest enabled slot.
            state       <= RUN;
            frame_buf   <= din;
            mask_buf    <= chan_mask;
            idx         <= cap_idx;
            s1          <= cap_idx[1];
            s2          <= cap_idx[0];
            d           <= din[cap_idx];
            valid       <= 1'b1;
            frame_start <= 1'b1;
            frame_end   <= cap_last;
        end else begin
            case (state)
                RUN: begin
                    if (!frame_end) begin
                        // Mid-frame: step to the next enabled channel.
                        idx         <= nxt_idx;
                        s1          <= nxt_idx[1];
                        s2          <= nxt_idx[0];
                        d           <= frame_buf[nxt_idx];
                        valid       <= 1'b1;
                        frame_start <= 1'b0;
                        frame_end   <= nxt_last;
                    end else begin
                        // Frame retired with no new request: go quiet.
                        state       <= IDLE;
                        idx         <= 2'd0;
                        s1          <= 1'b0;
                        s2          <= 1'b0;
                        d           <= 1'b0;
                        valid       <= 1'b0;
                        frame_start <= 1'b0;
                        frame_end   <= 1'b0;
                    end
                end
                default: begin
                    // IDLE without a capture: hold every output low.
                    state       <= IDLE;
                    s1          <= 1'b0;
                    s2          <= 1'b0;
                    d           <= 1'b0;
                    valid       <= 1'b0;
                    frame_start <= 1'b0;
                    frame_end   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tdm_mux4.sv
// -----------------------------------------------------------------------------
// tb_tdm_mux4
//
// Directed bench for tdm_mux4. A table of per-cycle records holds the inputs
// applied before a rising edge and the outputs expected just after it,
// packed as {valid, frame_start, frame_end, s1, s2, d}. Hand-written loops
// follow for the empty-mask hold and for continuous back-to-back framing.
// -----------------------------------------------------------------------------
module tb_tdm_mux4;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] din;
    logic [3:0] chan_mask;
    logic       s1;
    logic       s2;
    logic       d;
    logic       valid;
    logic       frame_start;
    logic       frame_end;

    int n_cmp = 0;
    int n_bad = 0;

    tdm_mux4 dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .din         (din),
        .chan_mask   (chan_mask),
        .s1          (s1),
        .s2          (s2),
        .d           (d),
        .valid       (valid),
        .frame_start (frame_start),
        .frame_end   (frame_end)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       en;
        logic [3:0] din;
        logic [3:0] mask;
        logic [5:0] exp;   // {valid, frame_start, frame_end, s1, s2, d}
        string      name;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [5:0] outs();
        return {valid, frame_start, frame_end, s1, s2, d};
    endfunction

    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got {v,fs,fe,s1,s2,d}=%b, required %b", name, act, exp);
        end
    endtask

    // Drive inputs away from the edge, then sample 1 time unit after it.
    task automatic step(input logic r, input logic e, input logic [3:0] di, input logic [3:0] m);
        @(negedge clk);
        rst       = r;
        en        = e;
        din       = di;
        chan_mask = m;
        @(posedge clk);
        #1;
    endtask

    task automatic add(input logic r, input logic e, input logic [3:0] di,
                       input logic [3:0] m, input logic [5:0] x, input string nm);
        vec_t v;
        v.rst  = r;
        v.en   = e;
        v.din  = di;
        v.mask = m;
        v.exp  = x;
        v.name = nm;
        vecs.push_back(v);
    endtask

    initial begin
        rst       = 1'b1;
        en        = 1'b0;
        din       = 4'd0;
        chan_mask = 4'd0;

        //   rst   en    din      mask     v fs fe s1s2 d
        // Reset state
        add(1'b1, 1'b0, 4'b0000, 4'b0000, 6'b000_000, "reset");
        // Full frame, en pulsed once; din=1010 -> d = 0,1,0,1
        add(1'b0, 1'b1, 4'b1010, 4'b1111, 6'b110_000, "full slot0");
        add(1'b0, 1'b0, 4'b1010, 4'b1111, 6'b100_011, "full slot1");
        add(1'b0, 1'b0, 4'b1010, 4'b1111, 6'b100_100, "full slot2");
        add(1'b0, 1'b0, 4'b1010, 4'b1111, 6'b101_111, "full slot3");
        add(1'b0, 1'b0, 4'b1010, 4'b1111, 6'b000_000, "full idle");
        // Sparse mask 0101, din 0100
        add(1'b0, 1'b1, 4'b0100, 4'b0101, 6'b110_000, "sparse slot0");
        add(1'b0, 1'b0, 4'b0100, 4'b0101, 6'b101_101, "sparse slot2");
        add(1'b0, 1'b0, 4'b0100, 4'b0101, 6'b000_000, "sparse idle");
        // Single channel 3
        add(1'b0, 1'b1, 4'b1000, 4'b1000, 6'b111_111, "single slot3");
        add(1'b0, 1'b0, 4'b1000, 4'b1000, 6'b000_000, "single idle");
        // Back-to-back, din changed mid frame 1
        add(1'b0, 1'b1, 4'b0001, 4'b0011, 6'b110_001, "b2b f1 slot0");
        add(1'b0, 1'b1, 4'b0010, 4'b0011, 6'b101_010, "b2b f1 slot1");
        add(1'b0, 1'b1, 4'b0010, 4'b0011, 6'b110_000, "b2b f2 slot0");
        add(1'b0, 1'b0, 4'b0010, 4'b0011, 6'b101_011, "b2b f2 slot1");
        add(1'b0, 1'b0, 4'b0010, 4'b0011, 6'b000_000, "b2b idle");
        // Reset on the second slot of a 1111 frame, then clean restart
        add(1'b0, 1'b1, 4'b1111, 4'b1111, 6'b110_001, "rstmid slot0");
        add(1'b0, 1'b0, 4'b1111, 4'b1111, 6'b100_011, "rstmid slot1");
        add(1'b1, 1'b0, 4'b1111, 4'b1111, 6'b000_000, "rstmid abort");
        add(1'b0, 1'b0, 4'b1111, 4'b1111, 6'b000_000, "rstmid stays idle");
        add(1'b0, 1'b1, 4'b1110, 4'b1111, 6'b110_000, "restart slot0");
        add(1'b0, 1'b0, 4'b1110, 4'b1111, 6'b100_011, "restart slot1");
        // Reset wins over a simultaneous request
        add(1'b1, 1'b1, 4'b1111, 4'b1111, 6'b000_000, "rst priority");
        add(1'b0, 1'b0, 4'b1111, 4'b1111, 6'b000_000, "rst priority idle");
        // Mask and din changed mid frame are ignored
        add(1'b0, 1'b1, 4'b0110, 4'b0110, 6'b110_011, "frozen slot1");
        add(1'b0, 1'b0, 4'b0000, 4'b1111, 6'b101_101, "frozen slot2");
        add(1'b0, 1'b0, 4'b0000, 4'b1111, 6'b000_000, "frozen idle");

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].en, vecs[i].din, vecs[i].mask);
            check(vecs[i].name, outs(), vecs[i].exp);
        end

        // Empty mask with en held: never leaves IDLE.
        for (int c = 0; c < 10; c++) begin
            step(1'b0, 1'b1, 4'b1111, 4'b0000);
            check($sformatf("empty mask cycle %0d", c), outs(), 6'b000_000);
        end

        // Continuous en with mask 0111: valid never drops, frame every 3 cycles.
        for (int c = 0; c < 12; c++) begin
            logic [3:0] pat;
            logic [1:0] slot;
            logic [5:0] x;
            pat  = 4'b0101;
            slot = 2'(c % 3);
            x    = {1'b1, (c % 3 == 0), (c % 3 == 2), slot, pat[slot]};
            step(1'b0, 1'b1, pat, 4'b0111);
            check($sformatf("continuous cycle %0d", c), outs(), x);
        end
        // Request dropped during the last frame: it completes then idles.
        step(1'b0, 1'b0, 4'b0101, 4'b0111);
        check("continuous drain", outs(), 6'b000_000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
